// File: rtl/cpu_mem_responder_if.sv
// CPU instruction/data bus plus program-loader port of cpu_mem_responder.
// Loader handshake: a word moves on every rising clk edge where ldValid and ldReady are both high.
interface cpu_mem_responder_if #(
  parameter int IMEM_AW = 12
);
  logic [IMEM_AW-1:0] instructionAddress;
  logic [31:0]        instructionIn;
  logic [13:0]        dataAddress;
  logic [31:0]        dataOut;
  logic               dataWrEn;
  logic [31:0]        dataIn;
  logic               ldStart;
  logic               ldDone;
  logic               ldValid;
  logic               ldReady;
  logic [IMEM_AW-1:0] ldAddr;
  logic [31:0]        ldData;
  logic               cpuHold;
  logic [7:0]         ledOut;

  modport master (
    output instructionAddress, dataAddress, dataOut, dataWrEn,
    output ldStart, ldDone, ldValid, ldAddr, ldData,
    input  instructionIn, dataIn, ldReady, cpuHold, ledOut
  );

  modport slave (
    input  instructionAddress, dataAddress, dataOut, dataWrEn,
    input  ldStart, ldDone, ldValid, ldAddr, ldData,
    output instructionIn, dataIn, ldReady, cpuHold, ledOut
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: instruction RAM with loader, data RAM and an I/O window (LED, cycle counter, status).
// Optional macro CYCLE_COUNTER_EN builds the free-running cycle counter at IO_BASE+1.
module cpu_mem_responder #(
  parameter int          IMEM_AW   = 12,
  parameter int          DMEM_AW   = 12,
  parameter logic [13:0] IO_BASE   = 14'h3F00,
  parameter int          HOLD_TAIL = 2
) (
  input  logic               clk,
  input  logic               nRst,
  cpu_mem_responder_if.slave bus,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  localparam int          TW       = (HOLD_TAIL > 1) ? $clog2(HOLD_TAIL) : 1;
  localparam logic [14:0] DMEM_TOP = 15'(2 ** DMEM_AW);

  state_t         r_state;
  logic           r_cpu_hold;
  logic           r_ld_ready;
  logic [TW-1:0]  r_tail_cnt;
  logic [7:0]     r_led;
  logic [31:0]    r_imem [0:(2**IMEM_AW)-1];
  logic [31:0]    r_dmem [0:(2**DMEM_AW)-1];

  logic           w_in_dmem;
  logic           w_in_io;
  logic [13:0]    w_io_off;
  logic           w_cpu_wr;
  logic           w_ld_xfer;
  logic [31:0]    w_cnt_rd;
  logic [31:0]    w_data_rd;

  assign w_in_dmem = {1'b0, bus.dataAddress} < DMEM_TOP;
  assign w_in_io   = bus.dataAddress >= IO_BASE;
  assign w_io_off  = bus.dataAddress - IO_BASE;
  assign w_cpu_wr  = bus.dataWrEn & ~nRst;
  assign w_ld_xfer = ~nRst & (r_state == S_LOAD) & r_ld_ready & bus.ldValid;

  // Loader FSM; cpuHold and ldReady are registered alongside the state.
  always_ff @(posedge clk) begin
    if (nRst) begin
      r_state    <= S_IDLE;
      r_cpu_hold <= 1'b0;
      r_ld_ready <= 1'b0;
      r_tail_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ldStart) begin
            r_state    <= S_LOAD;
            r_cpu_hold <= 1'b1;
            r_ld_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.ldDone) begin
            r_state    <= S_TAIL;
            r_ld_ready <= 1'b0;
            r_tail_cnt <= TW'(HOLD_TAIL - 1);
          end
        end
        S_TAIL: begin
          if (r_tail_cnt == '0) begin
            r_state    <= S_IDLE;
            r_cpu_hold <= 1'b0;
          end else begin
            r_tail_cnt <= r_tail_cnt - 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cpu_hold <= 1'b0;
          r_ld_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_xfer) r_imem[bus.ldAddr] <= bus.ldData;
  end

  always_ff @(posedge clk) begin
    if (w_cpu_wr && w_in_dmem) r_dmem[bus.dataAddress[DMEM_AW-1:0]] <= bus.dataOut;
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      r_led <= 8'h00;
    end else if (w_cpu_wr && w_in_io && (w_io_off == 14'd0)) begin
      r_led <= bus.dataOut[7:0];
    end
  end

`ifdef CYCLE_COUNTER_EN
  logic [31:0] r_cycle_cnt;

  // A CPU write clears the counter and takes priority over that cycle's increment.
  always_ff @(posedge clk) begin
    if (nRst) begin
      r_cycle_cnt <= 32'h0;
    end else if (w_cpu_wr && w_in_io && (w_io_off == 14'd1)) begin
      r_cycle_cnt <= 32'h0;
    end else if (!r_cpu_hold) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end

  assign w_cnt_rd = r_cycle_cnt;
`else
  assign w_cnt_rd = 32'h0;
`endif

  always_comb begin
    w_data_rd = 32'h0;
    if (w_in_dmem) begin
      w_data_rd = r_dmem[bus.dataAddress[DMEM_AW-1:0]];
    end else if (w_in_io) begin
      case (w_io_off)
        14'd0:   w_data_rd = {24'h0, r_led};
        14'd1:   w_data_rd = w_cnt_rd;
        14'd2:   w_data_rd = {30'h0, (r_state != S_IDLE), r_cpu_hold};
        default: w_data_rd = 32'h0;
      endcase
    end
  end

  assign bus.instructionIn = r_imem[bus.instructionAddress];
  assign bus.dataIn        = w_data_rd;
  assign bus.ldReady       = r_ld_ready;
  assign bus.cpuHold       = r_cpu_hold;
  assign bus.ledOut        = r_led;
  assign o_state           = r_state;

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU's instruction and data buses: instruction ROM/RAM, data RAM and a small memory-mapped I/O window.
- Includes a program-loader port with a valid/ready handshake. The loader fills instruction memory while holding the CPU in reset via cpuHold.
- Sits at the top level between the CPU and the board/host link.

Parameters:
- IMEM_AW, 12, instruction memory address width (4096 words).
- DMEM_AW, 12, data RAM address width (4096 words at data addresses 0x0000-0x0FFF).
- IO_BASE, 14'h3F00, base data address of the I/O window.
- HOLD_TAIL, 2, cycles cpuHold stays high after ldDone.

Ports:
- clk  in  1  clock.
- nRst  in  1  synchronous, active-high reset.
- instructionAddress  in  12  CPU fetch address.
- instructionIn  out  32  instruction word to CPU.
- dataAddress  in  14  CPU data address.
- dataOut  in  32  CPU write data.
- dataWrEn  in  1  CPU write strobe.
- dataIn  out  32  read data to CPU.
- ldStart  in  1  loader start pulse.
- ldDone  in  1  loader end pulse.
- ldValid  in  1  loader word valid.
- ldReady  out  1  loader may transfer.
- ldAddr  in  12  loader target instruction address.
- ldData  in  32  loader word.
- cpuHold  out  1  high keeps CPU in reset; top level drives the CPU reset from ~cpuHold.
- ledOut  out  8  LED register.

Behaviour:
- Reset (nRst=1 at posedge):
  - Loader FSM to IDLE.
  - cpuHold=0, ldReady=0, ledOut=0, cycle counter=0, tail counter=0.
  - Memory contents are not reset.
- Reads are zero-latency combinational:
  - instructionIn = imem[instructionAddress].
  - dataIn is a function of the current dataAddress.
  - The CPU registers dataAddress at one edge and samples dataIn at the next, so the read path must settle within one cycle.
- Data read map:
  - addr < 2^DMEM_AW: dmem[addr].
  - 2^DMEM_AW <= addr < IO_BASE: 32'h0.
  - IO_BASE+0: {24'h0, ledOut}.
  - IO_BASE+1: cycle counter.
  - IO_BASE+2: {30'h0, loaderBusy, cpuHold}, where loaderBusy = (state != IDLE).
  - IO_BASE+3 and above: 32'h0.
- Data writes, on posedge with dataWrEn=1, using the dataAddress/dataOut present that cycle:
  - RAM region: dmem written.
  - Hole: write dropped.
  - IO_BASE+0: ledOut <= dataOut[7:0].
  - IO_BASE+1: counter cleared to 0. The clear wins over the increment in that cycle.
  - IO_BASE+2 and above: write ignored.
- Cycle counter:
  - +1 every cycle while cpuHold=0.
  - Wraps from 32'hFFFFFFFF to 0.
  - Frozen while cpuHold=1.
- Loader FSM, states IDLE, LOAD, TAIL:
  - IDLE: ldReady=0. ldStart=1 -> LOAD, with cpuHold=1 and ldReady=1 from the next cycle.
  - LOAD:
    - ldReady=1. Each cycle with ldValid&ldReady writes imem[ldAddr] <= ldData.
    - ldStart is ignored.
    - ldDone=1 -> TAIL with tail counter=HOLD_TAIL-1 and ldReady=0 next cycle.
    - If ldValid and ldDone are high in the same cycle, that word is still written.
  - TAIL:
    - ldReady=0, cpuHold=1.
    - Counts down; at 0 -> IDLE, with cpuHold=0 from the next cycle.
    - ldStart is ignored.
  - ldStart and ldDone together in IDLE: ldStart wins, ldDone is ignored (stays in LOAD).
- CPU data writes while cpuHold=1 are still honoured. The held CPU produces none; this is not checked.
- Reset mid-load (nRst=1 in LOAD or TAIL): immediate return to IDLE and cpuHold=0. Words already written remain; a write in the reset cycle is dropped.
- Loader and CPU fetch never conflict (the CPU is held). Simultaneous loader write and CPU fetch of the same address returns the old word combinationally.

Optional Feature:
- CYCLE_COUNTER_EN
  - Defined: cycle counter at IO_BASE+1 behaves as described above.
  - Undefined: no counter register is built; IO_BASE+1 reads 32'h0 and writes to it are ignored.

Test Plan:
- Reset, then CPU writes 32'hDEADBEEF to 0x0010 -> next cycle, dataAddress=0x0010 gives dataIn=32'hDEADBEEF. Address 0x1234 reads 0; a write to it leaves 0x0234 unchanged.
- Write 32'h1A5 to IO_BASE+0 -> ledOut=8'hA5; reading IO_BASE+0 returns 32'h000000A5.
- Counter:
  - 10 cycles after reset with cpuHold=0, IO_BASE+1 reads 10 (±read-cycle alignment checked exactly against the model).
  - Write to IO_BASE+1 -> reads 1 the next cycle.
  - With CYCLE_COUNTER_EN undefined -> always 0.
- Loader:
  - ldStart -> cpuHold=1 next cycle.
  - Three handshakes write 0x000=32'h11, 0x001=32'h22, 0x7FF=32'h33; ldValid with ldReady=0 in IDLE writes nothing.
  - ldDone -> cpuHold falls exactly HOLD_TAIL+1 cycles later.
  - instructionIn matches at each address afterwards.
- ldStart+ldDone in the same IDLE cycle -> FSM in LOAD, ldReady=1. nRst asserted during LOAD -> cpuHold=0 and ldReady=0 after the edge; IO_BASE+2 reads 0.
- Counter preset near 32'hFFFFFFFF (force) -> wraps to 0. The counter stays frozen across a load sequence.
